// File: rtl/ring_pkg.sv
// Shared constants, state encoding and token helpers for the 2-bit rotating ring pattern.
package ring_pkg;

    localparam int unsigned RING_WIDTH = 8;
    localparam int unsigned RING_STEP  = 2;
    localparam int unsigned RING_TOKENS = RING_WIDTH / RING_STEP;
    localparam int unsigned RING_PHASE_W = (RING_TOKENS > 1) ? $clog2(RING_TOKENS) : 1;
    localparam logic [RING_WIDTH-1:0] RING_SEED = 8'b0000_0011;

    typedef logic [1:0] ring_state_t;
    localparam ring_state_t HUNT   = 2'd0;
    localparam ring_state_t CHECK  = 2'd1;
    localparam ring_state_t LOCKED = 2'd2;

    function automatic logic [RING_WIDTH-1:0] rotl_step(input logic [RING_WIDTH-1:0] value);
        return {value[RING_WIDTH-RING_STEP-1:0], value[RING_WIDTH-1:RING_WIDTH-RING_STEP]};
    endfunction

    function automatic logic is_legal(input logic [RING_WIDTH-1:0] value);
        logic ok;
        ok = 1'b0;
        for (int unsigned k = 0; k < RING_TOKENS; k++) begin
            if (value == (RING_SEED << (k * RING_STEP))) ok = 1'b1;
        end
        return ok;
    endfunction

    function automatic logic [RING_PHASE_W-1:0] decode_phase(input logic [RING_WIDTH-1:0] value);
        logic [RING_PHASE_W-1:0] ph;
        ph = '0;
        for (int unsigned k = 0; k < RING_TOKENS; k++) begin
            if (value == (RING_SEED << (k * RING_STEP))) ph = RING_PHASE_W'(k);
        end
        return ph;
    endfunction

endpackage

// File: rtl/ring_token_decode.sv
// Combinational token decoder: flags a legal single-token pattern and returns its position.
module ring_token_decode
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH   = RING_WIDTH,
    parameter int unsigned STEP    = RING_STEP,
    parameter int unsigned PHASE_W = ((WIDTH / STEP) > 1) ? $clog2(WIDTH / STEP) : 1
) (
    input  logic [WIDTH-1:0]   pat,
    output logic               legal_c,
    output logic [PHASE_W-1:0] phase_c
);

    localparam int unsigned NTOK = WIDTH / STEP;
    localparam logic [WIDTH-1:0] TOKEN = WIDTH'((64'd1 << STEP) - 64'd1);

    // Exactly one aligned run of STEP ones, everything else zero.
    always_comb begin
        legal_c = 1'b0;
        phase_c = '0;
        for (int unsigned k = 0; k < NTOK; k++) begin
            if (pat == (TOKEN << (k * STEP))) begin
                legal_c = 1'b1;
                phase_c = PHASE_W'(k);
            end
        end
    end

endmodule

// File: rtl/ring_pattern_checker.sv
// Ring pattern receiver: hunts for a legal token, confirms rotation, then flywheels
// through the sequence while flagging and counting mismatching samples.
module ring_pattern_checker
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH      = RING_WIDTH,
    parameter int unsigned STEP       = RING_STEP,
    parameter int unsigned LOCK_CNT   = 3,
    parameter int unsigned UNLOCK_CNT = 2,
    localparam int unsigned PHASE_W   = ((WIDTH / STEP) > 1) ? $clog2(WIDTH / STEP) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pat_valid,
    input  logic [WIDTH-1:0]   pat,
    output logic               locked,
    output logic [PHASE_W-1:0] phase,
    output logic               err,
    output logic [7:0]         err_count
);

    localparam int unsigned RUN_W  = (LOCK_CNT > 1)   ? $clog2(LOCK_CNT + 1)   : 1;
    localparam int unsigned MISS_W = (UNLOCK_CNT > 1) ? $clog2(UNLOCK_CNT + 1) : 1;

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v);
        return {v[WIDTH-STEP-1:0], v[WIDTH-1:WIDTH-STEP]};
    endfunction

    ring_state_t          state_q, state_d;
    logic [WIDTH-1:0]     expected_q, expected_d;
    logic [RUN_W-1:0]     run_q, run_d;
    logic [MISS_W-1:0]    miss_q, miss_d;
    logic                 locked_d;
    logic [PHASE_W-1:0]   phase_d;
    logic                 err_d;
    logic [7:0]           err_count_d;

    logic                 legal_c;
    logic [PHASE_W-1:0]   pat_phase_c;
    logic                 match_c;
    logic [RUN_W-1:0]     run_inc_c;
    logic [MISS_W-1:0]    miss_inc_c;

    ring_token_decode #(
        .WIDTH   (WIDTH),
        .STEP    (STEP),
        .PHASE_W (PHASE_W)
    ) u_decode (
        .pat     (pat),
        .legal_c (legal_c),
        .phase_c (pat_phase_c)
    );

    assign match_c    = (pat == expected_q);
    assign run_inc_c  = run_q + RUN_W'(1);
    assign miss_inc_c = miss_q + MISS_W'(1);

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HUNT;
            expected_q <= '0;
            run_q      <= '0;
            miss_q     <= '0;
            locked     <= 1'b0;
            phase      <= '0;
            err        <= 1'b0;
            err_count  <= '0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            run_q      <= run_d;
            miss_q     <= miss_d;
            locked     <= locked_d;
            phase      <= phase_d;
            err        <= err_d;
            err_count  <= err_count_d;
        end
    end

    // Next-state and next-output logic; idle cycles hold everything except err.
    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        run_d       = run_q;
        miss_d      = miss_q;
        locked_d    = locked;
        phase_d     = phase;
        err_d       = 1'b0;
        err_count_d = err_count;

        if (pat_valid) begin
            case (state_q)
                HUNT: begin
                    if (legal_c) begin
                        run_d      = RUN_W'(1);
                        expected_d = rotl(pat);
                        phase_d    = pat_phase_c;
                        if (LOCK_CNT <= 1) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            miss_d   = '0;
                        end else begin
                            state_d  = CHECK;
                        end
                    end
                end

                CHECK: begin
                    if (match_c) begin
                        run_d      = run_inc_c;
                        expected_d = rotl(pat);
                        phase_d    = pat_phase_c;
                        if (run_inc_c == RUN_W'(LOCK_CNT)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            miss_d   = '0;
                        end
                    end else if (legal_c) begin
                        // Legal but out of sequence: restart confirmation from this sample.
                        run_d      = RUN_W'(1);
                        expected_d = rotl(pat);
                        phase_d    = pat_phase_c;
                    end else begin
                        state_d = HUNT;
                        run_d   = '0;
                    end
                end

                LOCKED: begin
                    if (match_c) begin
                        miss_d     = '0;
                        expected_d = rotl(pat);
                        phase_d    = pat_phase_c;
                    end else begin
                        err_d = 1'b1;
                        if (err_count != 8'hFF) err_count_d = err_count + 8'd1;
                        if (miss_inc_c == MISS_W'(UNLOCK_CNT)) begin
                            state_d  = HUNT;
                            locked_d = 1'b0;
                            miss_d   = '0;
                            run_d    = '0;
                        end else begin
                            // Flywheel: advance the expectation without trusting pat.
                            miss_d     = miss_inc_c;
                            expected_d = rotl(expected_q);
                        end
                    end
                end

                default: begin
                    state_d  = HUNT;
                    run_d    = '0;
                    miss_d   = '0;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_pattern_checker.sv
// Directed self-checking bench for ring_pattern_checker with hand-computed expectations.
module tb_ring_pattern_checker;

    logic       clk;
    logic       rst;
    logic       pat_valid;
    logic [7:0] pat;
    logic       locked;
    logic [1:0] phase;
    logic       err;
    logic [7:0] err_count;

    int checks;
    int errors;

    ring_pattern_checker dut (
        .clk       (clk),
        .rst       (rst),
        .pat_valid (pat_valid),
        .pat       (pat),
        .locked    (locked),
        .phase     (phase),
        .err       (err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic send(input logic [7:0] p);
        @(negedge clk);
        pat_valid = 1'b1;
        pat       = p;
        @(posedge clk);
        #1;
        pat_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            pat_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] rotl2(input logic [7:0] v);
        return {v[5:0], v[7:6]};
    endfunction

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] e;
        int exp_cnt;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        pat_valid = 1'b0;
        pat       = 8'h00;
        #1;
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cnt", 32'(err_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Illegal patterns in HUNT are ignored.
        send(8'h05); check("hunt_ill_locked", 32'(locked), 32'd0);
        send(8'h0F); check("hunt_ill_phase", 32'(phase), 32'd0);

        // Acquisition and phase wrap.
        send(8'h03); check("acq1_locked", 32'(locked), 32'd0);
        send(8'h0C); check("acq2_locked", 32'(locked), 32'd0);
        send(8'h30); check("acq3_locked", 32'(locked), 32'd1);
        check("acq3_phase", 32'(phase), 32'd2);
        check("acq3_err", 32'(err), 32'd0);
        send(8'hC0); check("wrap_phase3", 32'(phase), 32'd3);
        send(8'h03); check("wrap_phase0", 32'(phase), 32'd0);
        check("wrap_err", 32'(err), 32'd0);

        // Loss of lock: expected 0x0C.
        send(8'h00); check("lol1_err", 32'(err), 32'd1);
        check("lol1_cnt", 32'(err_count), 32'd1);
        check("lol1_locked", 32'(locked), 32'd1);
        send(8'h00); check("lol2_err", 32'(err), 32'd1);
        check("lol2_cnt", 32'(err_count), 32'd2);
        check("lol2_locked", 32'(locked), 32'd0);
        idle(1); check("lol_err_clear", 32'(err), 32'd0);
        send(8'h03); send(8'h0C);
        check("relock_pre", 32'(locked), 32'd0);
        send(8'h30);
        check("relock_locked", 32'(locked), 32'd1);
        check("relock_cnt", 32'(err_count), 32'd2);

        // Single glitch: advance until expected 0x30.
        send(8'hC0); send(8'h03); send(8'h0C);
        send(8'h31); check("glitch_err", 32'(err), 32'd1);
        check("glitch_cnt", 32'(err_count), 32'd3);
        check("glitch_locked", 32'(locked), 32'd1);
        check("glitch_phase_hold", 32'(phase), 32'd1);
        send(8'hC0); check("fly_err", 32'(err), 32'd0);
        check("fly_phase", 32'(phase), 32'd3);
        check("fly_cnt", 32'(err_count), 32'd3);
        // A further single miss must not unlock, proving miss cleared.
        send(8'h00); check("miss_clr_locked", 32'(locked), 32'd1);
        check("miss_clr_cnt", 32'(err_count), 32'd4);
        send(8'h0C); check("miss_clr_match", 32'(err), 32'd0);
        check("miss_clr_phase", 32'(phase), 32'd1);

        // Idle gap while locked changes nothing; expected still 0x30.
        idle(5);
        check("gap_locked", 32'(locked), 32'd1);
        check("gap_phase", 32'(phase), 32'd1);
        check("gap_cnt", 32'(err_count), 32'd4);
        check("gap_err", 32'(err), 32'd0);
        send(8'h30); check("gap_resume", 32'(phase), 32'd2);
        check("gap_resume_err", 32'(err), 32'd0);

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        #1;
        check("arst_locked", 32'(locked), 32'd0);
        check("arst_cnt", 32'(err_count), 32'd0);
        check("arst_phase", 32'(phase), 32'd0);
        @(negedge clk);
        pat_valid = 1'b1;
        pat       = 8'h0C;
        @(posedge clk);
        #1;
        check("rst_wins_phase", 32'(phase), 32'd0);
        check("rst_wins_locked", 32'(locked), 32'd0);
        @(negedge clk);
        pat_valid = 1'b0;
        rst       = 1'b0;

        // Illegal in CHECK drops to HUNT, then a fresh run of three is required.
        send(8'h03); send(8'h0C);
        send(8'hFF); check("chk_ill_locked", 32'(locked), 32'd0);
        send(8'h30); send(8'hC0);
        check("chk_ill_two", 32'(locked), 32'd0);
        send(8'h03); check("chk_ill_relock", 32'(locked), 32'd1);

        // Reseed in CHECK with an idle gap.
        #2; rst = 1'b1; #1; @(negedge clk); rst = 1'b0;
        send(8'h03);
        send(8'h30); check("reseed_locked", 32'(locked), 32'd0);
        idle(5);
        check("reseed_gap_locked", 32'(locked), 32'd0);
        send(8'hC0); check("reseed_run2", 32'(locked), 32'd0);
        send(8'h03); check("reseed_lock", 32'(locked), 32'd1);
        check("reseed_phase", 32'(phase), 32'd0);
        check("reseed_err", 32'(err), 32'd0);

        // Saturation: alternate miss and flywheel match; expected starts 0x0C.
        e = 8'h0C;
        exp_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            send(8'h00);
            if (exp_cnt < 255) exp_cnt++;
            check("sat_err", 32'(err), 32'd1);
            check("sat_cnt", 32'(err_count), 32'(exp_cnt));
            e = rotl2(e);
            send(e);
            e = rotl2(e);
            check("sat_locked", 32'(locked), 32'd1);
        end
        check("sat_final", 32'(err_count), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
